// File: rtl/axi_master_compare.sv
// Lock-step comparator for two AXI4+ATOP masters sharing one slave: joins the request
// channels, forks B/R back to both masters and records payload divergence.
package axi_master_compare_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } rsp_t;

endpackage

module axi_master_compare #(
    parameter int unsigned MaxTxns       = 32'd8,
    parameter type         axi_aw_chan_t = axi_master_compare_pkg::aw_chan_t,
    parameter type         axi_w_chan_t  = axi_master_compare_pkg::w_chan_t,
    parameter type         axi_ar_chan_t = axi_master_compare_pkg::ar_chan_t,
    parameter type         axi_req_t     = axi_master_compare_pkg::req_t,
    parameter type         axi_rsp_t     = axi_master_compare_pkg::rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  axi_req_t    axi_ref_req_i,
    output axi_rsp_t    axi_ref_rsp_o,
    input  axi_req_t    axi_test_req_i,
    output axi_rsp_t    axi_test_rsp_o,
    output axi_req_t    axi_slv_req_o,
    input  axi_rsp_t    axi_slv_rsp_i,
    output logic        aw_mismatch_o,
    output logic        w_mismatch_o,
    output logic        ar_mismatch_o,
    output logic        mismatch_o,
    output logic [15:0] mismatch_cnt_o
    ,
    output logic        busy_o
);

    localparam int unsigned     CntW   = $clog2(MaxTxns + 32'd1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntZero = CntW'(0);

    axi_aw_chan_t aw_ref_s, aw_test_s;
    axi_w_chan_t  w_ref_s, w_test_s;
    axi_ar_chan_t ar_ref_s, ar_test_s;

    logic [CntW-1:0] aw_cnt_q, aw_cnt_d, ar_cnt_q, ar_cnt_d;
    logic b_done_ref_q, b_done_ref_d, b_done_test_q, b_done_test_d;
    logic r_done_ref_q, r_done_ref_d, r_done_test_q, r_done_test_d;
    logic aw_mis_q, aw_mis_d, w_mis_q, w_mis_d, ar_mis_q, ar_mis_d;
    logic [15:0] mis_cnt_q, mis_cnt_d;

    logic aw_join_s, w_join_s, ar_join_s;
    logic aw_hs_s, w_hs_s, ar_hs_s;
    logic aw_neq_s, w_neq_s, ar_neq_s;
    logic slv_b_ready_s, slv_r_ready_s, slv_b_hs_s, slv_r_hs_s, slv_r_last_hs_s;
    logic ref_b_hs_s, test_b_hs_s, ref_r_hs_s, test_r_hs_s;
    logic [1:0]  n_mis_s;
    logic [16:0] mis_sum_s;

    assign aw_ref_s  = axi_ref_req_i.aw;
    assign aw_test_s = axi_test_req_i.aw;
    assign w_ref_s   = axi_ref_req_i.w;
    assign w_test_s  = axi_test_req_i.w;
    assign ar_ref_s  = axi_ref_req_i.ar;
    assign ar_test_s = axi_test_req_i.ar;

    // Joins stall on the registered count, so a same-cycle retirement only frees a slot next cycle.
    assign aw_join_s = axi_ref_req_i.aw_valid & axi_test_req_i.aw_valid & (aw_cnt_q < MaxCnt);
    assign w_join_s  = axi_ref_req_i.w_valid & axi_test_req_i.w_valid;
    assign ar_join_s = axi_ref_req_i.ar_valid & axi_test_req_i.ar_valid & (ar_cnt_q < MaxCnt);

    assign aw_hs_s = aw_join_s & axi_slv_rsp_i.aw_ready;
    assign w_hs_s  = w_join_s & axi_slv_rsp_i.w_ready;
    assign ar_hs_s = ar_join_s & axi_slv_rsp_i.ar_ready;

    assign aw_neq_s = aw_hs_s & (aw_ref_s != aw_test_s);
    assign w_neq_s  = w_hs_s & (w_ref_s != w_test_s);
    assign ar_neq_s = ar_hs_s & (ar_ref_s != ar_test_s);

    assign slv_b_ready_s = (axi_ref_req_i.b_ready | b_done_ref_q) & (axi_test_req_i.b_ready | b_done_test_q);
    assign slv_r_ready_s = (axi_ref_req_i.r_ready | r_done_ref_q) & (axi_test_req_i.r_ready | r_done_test_q);
    assign slv_b_hs_s      = axi_slv_rsp_i.b_valid & slv_b_ready_s;
    assign slv_r_hs_s      = axi_slv_rsp_i.r_valid & slv_r_ready_s;
    assign slv_r_last_hs_s = slv_r_hs_s & axi_slv_rsp_i.r.last;

    assign ref_b_hs_s  = axi_slv_rsp_i.b_valid & ~b_done_ref_q & axi_ref_req_i.b_ready;
    assign test_b_hs_s = axi_slv_rsp_i.b_valid & ~b_done_test_q & axi_test_req_i.b_ready;
    assign ref_r_hs_s  = axi_slv_rsp_i.r_valid & ~r_done_ref_q & axi_ref_req_i.r_ready;
    assign test_r_hs_s = axi_slv_rsp_i.r_valid & ~r_done_test_q & axi_test_req_i.r_ready;

    // Channel routing toward the slave and both masters.
    always_comb begin
        axi_slv_req_o          = '0;
        axi_slv_req_o.aw       = axi_ref_req_i.aw;
        axi_slv_req_o.aw_valid = aw_join_s;
        axi_slv_req_o.w        = axi_ref_req_i.w;
        axi_slv_req_o.w_valid  = w_join_s;
        axi_slv_req_o.ar       = axi_ref_req_i.ar;
        axi_slv_req_o.ar_valid = ar_join_s;
        axi_slv_req_o.b_ready  = slv_b_ready_s;
        axi_slv_req_o.r_ready  = slv_r_ready_s;

        axi_ref_rsp_o          = '0;
        axi_ref_rsp_o.aw_ready = axi_slv_rsp_i.aw_ready & aw_join_s;
        axi_ref_rsp_o.w_ready  = axi_slv_rsp_i.w_ready & w_join_s;
        axi_ref_rsp_o.ar_ready = axi_slv_rsp_i.ar_ready & ar_join_s;
        axi_ref_rsp_o.b_valid  = axi_slv_rsp_i.b_valid & ~b_done_ref_q;
        axi_ref_rsp_o.b        = axi_slv_rsp_i.b;
        axi_ref_rsp_o.r_valid  = axi_slv_rsp_i.r_valid & ~r_done_ref_q;
        axi_ref_rsp_o.r        = axi_slv_rsp_i.r;

        axi_test_rsp_o          = '0;
        axi_test_rsp_o.aw_ready = axi_slv_rsp_i.aw_ready & aw_join_s;
        axi_test_rsp_o.w_ready  = axi_slv_rsp_i.w_ready & w_join_s;
        axi_test_rsp_o.ar_ready = axi_slv_rsp_i.ar_ready & ar_join_s;
        axi_test_rsp_o.b_valid  = axi_slv_rsp_i.b_valid & ~b_done_test_q;
        axi_test_rsp_o.b        = axi_slv_rsp_i.b;
        axi_test_rsp_o.r_valid  = axi_slv_rsp_i.r_valid & ~r_done_test_q;
        axi_test_rsp_o.r        = axi_slv_rsp_i.r;
    end

    // Next-state for counters, fork bookkeeping and mismatch tracking.
    always_comb begin
        aw_cnt_d = aw_cnt_q;
        ar_cnt_d = ar_cnt_q;
        case ({aw_hs_s, slv_b_hs_s && (aw_cnt_q != CntZero)})
            2'b10:   aw_cnt_d = aw_cnt_q + CntOne;
            2'b01:   aw_cnt_d = aw_cnt_q - CntOne;
            default: aw_cnt_d = aw_cnt_q;
        endcase
        case ({ar_hs_s, slv_r_last_hs_s && (ar_cnt_q != CntZero)})
            2'b10:   ar_cnt_d = ar_cnt_q + CntOne;
            2'b01:   ar_cnt_d = ar_cnt_q - CntOne;
            default: ar_cnt_d = ar_cnt_q;
        endcase

        b_done_ref_d  = slv_b_hs_s ? 1'b0 : (b_done_ref_q  | (ref_b_hs_s  & ~slv_b_ready_s));
        b_done_test_d = slv_b_hs_s ? 1'b0 : (b_done_test_q | (test_b_hs_s & ~slv_b_ready_s));
        r_done_ref_d  = slv_r_hs_s ? 1'b0 : (r_done_ref_q  | (ref_r_hs_s  & ~slv_r_ready_s));
        r_done_test_d = slv_r_hs_s ? 1'b0 : (r_done_test_q | (test_r_hs_s & ~slv_r_ready_s));

        aw_mis_d  = aw_mis_q | aw_neq_s;
        w_mis_d   = w_mis_q | w_neq_s;
        ar_mis_d  = ar_mis_q | ar_neq_s;
        n_mis_s   = {1'b0, aw_neq_s} + {1'b0, w_neq_s} + {1'b0, ar_neq_s};
        mis_sum_s = {1'b0, mis_cnt_q} + {15'd0, n_mis_s};
        mis_cnt_d = mis_sum_s[16] ? 16'hFFFF : mis_sum_s[15:0];
    end

    // State registers with synchronous reset that drops all in-flight bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_cnt_q      <= CntZero;
            ar_cnt_q      <= CntZero;
            b_done_ref_q  <= 1'b0;
            b_done_test_q <= 1'b0;
            r_done_ref_q  <= 1'b0;
            r_done_test_q <= 1'b0;
            aw_mis_q      <= 1'b0;
            w_mis_q       <= 1'b0;
            ar_mis_q      <= 1'b0;
            mis_cnt_q     <= 16'd0;
        end else begin
            aw_cnt_q      <= aw_cnt_d;
            ar_cnt_q      <= ar_cnt_d;
            b_done_ref_q  <= b_done_ref_d;
            b_done_test_q <= b_done_test_d;
            r_done_ref_q  <= r_done_ref_d;
            r_done_test_q <= r_done_test_d;
            aw_mis_q      <= aw_mis_d;
            w_mis_q       <= w_mis_d;
            ar_mis_q      <= ar_mis_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign aw_mismatch_o  = aw_mis_q;
    assign w_mismatch_o   = w_mis_q;
    assign ar_mismatch_o  = ar_mis_q;
    assign mismatch_o     = aw_mis_q | w_mis_q | ar_mis_q;
    assign mismatch_cnt_o = mis_cnt_q;
    assign busy_o = (aw_cnt_q != CntZero) | (ar_cnt_q != CntZero) |
                    b_done_ref_q | b_done_test_q | r_done_ref_q | r_done_test_q;

endmodule

// File: tb/tb_axi_master_compare.sv
// Directed bench for axi_master_compare (MaxTxns=2): stimulus pushes expected forwarded
// payloads into queues, a negedge monitor pops them on every observed handshake.
module tb_axi_master_compare;
    import axi_master_compare_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    req_t        ref_req, test_req, slv_req;
    rsp_t        ref_rsp, test_rsp, slv_rsp;
    logic        aw_mis, w_mis, ar_mis, mis, busy;
    logic [15:0] mis_cnt;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [31:0] q_aw[$], q_w[$], q_ar[$];
    logic [3:0]  q_bref[$], q_btest[$], q_rref[$], q_rtest[$];

    always #5 clk = ~clk;

    axi_master_compare #(
        .MaxTxns      (2),
        .axi_aw_chan_t(aw_chan_t),
        .axi_w_chan_t (w_chan_t),
        .axi_ar_chan_t(ar_chan_t),
        .axi_req_t    (req_t),
        .axi_rsp_t    (rsp_t)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .axi_ref_req_i (ref_req),
        .axi_ref_rsp_o (ref_rsp),
        .axi_test_req_i(test_req),
        .axi_test_rsp_o(test_rsp),
        .axi_slv_req_o (slv_req),
        .axi_slv_rsp_i (slv_rsp),
        .aw_mismatch_o (aw_mis),
        .w_mismatch_o  (w_mis),
        .ar_mismatch_o (ar_mis),
        .mismatch_o    (mis),
        .mismatch_cnt_o(mis_cnt),
        .busy_o        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: handshake with empty expectation queue (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: one pop per handshake seen on each channel.
    always @(negedge clk) begin
        if (!rst) begin
            if (slv_req.aw_valid && slv_rsp.aw_ready) begin
                if (q_aw.size() == 0) unexpected("aw_hs");
                else check("aw_addr", slv_req.aw.addr, q_aw.pop_front());
                check("aw_ready_both", {30'd0, ref_rsp.aw_ready, test_rsp.aw_ready}, 32'd3);
            end
            if (slv_req.w_valid && slv_rsp.w_ready) begin
                if (q_w.size() == 0) unexpected("w_hs");
                else check("w_data", slv_req.w.data, q_w.pop_front());
            end
            if (slv_req.ar_valid && slv_rsp.ar_ready) begin
                if (q_ar.size() == 0) unexpected("ar_hs");
                else check("ar_addr", slv_req.ar.addr, q_ar.pop_front());
                check("ar_ready_both", {30'd0, ref_rsp.ar_ready, test_rsp.ar_ready}, 32'd3);
            end
            if (ref_rsp.b_valid && ref_req.b_ready) begin
                if (q_bref.size() == 0) unexpected("b_ref_hs");
                else check("b_ref_id", {28'd0, ref_rsp.b.id}, {28'd0, q_bref.pop_front()});
            end
            if (test_rsp.b_valid && test_req.b_ready) begin
                if (q_btest.size() == 0) unexpected("b_test_hs");
                else check("b_test_id", {28'd0, test_rsp.b.id}, {28'd0, q_btest.pop_front()});
            end
            if (ref_rsp.r_valid && ref_req.r_ready) begin
                if (q_rref.size() == 0) unexpected("r_ref_hs");
                else check("r_ref_id", {28'd0, ref_rsp.r.id}, {28'd0, q_rref.pop_front()});
            end
            if (test_rsp.r_valid && test_req.r_ready) begin
                if (q_rtest.size() == 0) unexpected("r_test_hs");
                else check("r_test_id", {28'd0, test_rsp.r.id}, {28'd0, q_rtest.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic triple_mismatch();
        ref_req.aw.addr  = 32'h2000; test_req.aw.addr = 32'h2004;
        ref_req.w.data   = 32'h11;   test_req.w.data  = 32'h22;
        ref_req.ar.addr  = 32'h3000; test_req.ar.addr = 32'h3004;
        ref_req.aw_valid = 1'b1; test_req.aw_valid = 1'b1;
        ref_req.w_valid  = 1'b1; test_req.w_valid  = 1'b1;
        ref_req.ar_valid = 1'b1; test_req.ar_valid = 1'b1;
        q_aw.push_back(32'h2000);
        q_w.push_back(32'h11);
        q_ar.push_back(32'h3000);
    endtask

    task automatic both_responses(input logic on);
        slv_rsp.b_valid  = on; slv_rsp.r_valid  = on;
        ref_req.b_ready  = on; test_req.b_ready = on;
        ref_req.r_ready  = on; test_req.r_ready = on;
        if (on) begin
            q_bref.push_back(4'd5); q_btest.push_back(4'd5);
            q_rref.push_back(4'd6); q_rtest.push_back(4'd6);
        end
    endtask

    task automatic drop_requests();
        ref_req.aw_valid = 1'b0; test_req.aw_valid = 1'b0;
        ref_req.w_valid  = 1'b0; test_req.w_valid  = 1'b0;
        ref_req.ar_valid = 1'b0; test_req.ar_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ref_req = '0; test_req = '0; slv_rsp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mismatch", {31'd0, mis}, 32'd0);
        check("rst_flags", {29'd0, aw_mis, w_mis, ar_mis}, 32'd0);
        check("rst_cnt", {16'd0, mis_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Identical AW joined in one cycle
        slv_rsp.aw_ready = 1'b1; slv_rsp.w_ready = 1'b1; slv_rsp.ar_ready = 1'b1;
        ref_req.aw.addr = 32'h1000; ref_req.aw.id = 4'd2; test_req.aw = ref_req.aw;
        ref_req.aw_valid = 1'b1; test_req.aw_valid = 1'b1;
        q_aw.push_back(32'h1000);
        #1 check("aw_join_same_cycle", {31'd0, slv_req.aw_valid}, 32'd1);
        step(); drop_requests();
        check("aw_match_flag", {31'd0, aw_mis}, 32'd0);
        check("aw_cnt_one", 32'(dut.aw_cnt_q), 32'd1);
        check("busy_after_aw", {31'd0, busy}, 32'd1);

        // Diverging AW address; reference payload forwarded
        test_req.aw.addr = 32'h1004;
        ref_req.aw_valid = 1'b1; test_req.aw_valid = 1'b1;
        q_aw.push_back(32'h1000);
        step(); drop_requests();
        check("aw_mis_flag", {31'd0, aw_mis}, 32'd1);
        check("mis_cnt_one", {16'd0, mis_cnt}, 32'd1);
        check("mismatch_or", {31'd0, mis}, 32'd1);
        repeat (100) step();
        check("aw_mis_sticky", {31'd0, aw_mis}, 32'd1);
        check("aw_cnt_two", 32'(dut.aw_cnt_q), 32'd2);

        // B fork: test master lags by three cycles
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd2;
        ref_req.b_ready = 1'b1; test_req.b_ready = 1'b0;
        q_bref.push_back(4'd2);
        #1 check("slv_b_ready_c1", {31'd0, slv_req.b_ready}, 32'd0);
        step();
        check("ref_b_valid_done", {31'd0, ref_rsp.b_valid}, 32'd0);
        check("test_b_valid_c2", {31'd0, test_rsp.b_valid}, 32'd1);
        check("slv_b_ready_c2", {31'd0, slv_req.b_ready}, 32'd0);
        step();
        check("slv_b_ready_c3", {31'd0, slv_req.b_ready}, 32'd0);
        step();
        test_req.b_ready = 1'b1;
        q_btest.push_back(4'd2);
        #1 check("slv_b_ready_c4", {31'd0, slv_req.b_ready}, 32'd1);
        step();
        check("aw_cnt_after_b", 32'(dut.aw_cnt_q), 32'd1);
        q_bref.push_back(4'd2); q_btest.push_back(4'd2);
        step();
        slv_rsp.b_valid = 1'b0; ref_req.b_ready = 1'b0; test_req.b_ready = 1'b0;
        check("aw_cnt_zero", 32'(dut.aw_cnt_q), 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);

        // Three channels mismatching in one cycle, then drive the count to saturation
        triple_mismatch();
        step();
        check("mis_cnt_plus3", {16'd0, mis_cnt}, 32'd4);
        check("all_flags", {29'd0, aw_mis, w_mis, ar_mis}, 32'd7);
        slv_rsp.b.id = 4'd5; slv_rsp.r.id = 4'd6; slv_rsp.r.last = 1'b1;
        for (int i = 0; i < 21843; i++) begin
            triple_mismatch();
            both_responses(1'b1);
            step();
        end
        both_responses(1'b0);
        drop_requests();
        check("mis_cnt_fffd", {16'd0, mis_cnt}, 32'h0000FFFD);
        ref_req.w_valid = 1'b1; test_req.w_valid = 1'b1;
        q_w.push_back(32'h11);
        step(); drop_requests();
        check("mis_cnt_fffe", {16'd0, mis_cnt}, 32'h0000FFFE);
        check("aw_cnt_steady", 32'(dut.aw_cnt_q), 32'd1);
        triple_mismatch(); both_responses(1'b1);
        step();
        check("mis_cnt_sat", {16'd0, mis_cnt}, 32'h0000FFFF);
        triple_mismatch(); both_responses(1'b1);
        step();
        check("mis_cnt_hold", {16'd0, mis_cnt}, 32'h0000FFFF);
        drop_requests(); both_responses(1'b1);
        step(); both_responses(1'b0);
        check("busy_drained", {31'd0, busy}, 32'd0);

        // AR stall at MaxTxns=2
        ref_req.ar.addr = 32'h4000; test_req.ar = ref_req.ar;
        ref_req.ar_valid = 1'b1; test_req.ar_valid = 1'b1;
        q_ar.push_back(32'h4000); step();
        q_ar.push_back(32'h4000); step();
        check("ar_stall_ready", {30'd0, ref_rsp.ar_ready, test_rsp.ar_ready}, 32'd0);
        check("ar_stall_slv_valid", {31'd0, slv_req.ar_valid}, 32'd0);
        check("ar_stall_busy", {31'd0, busy}, 32'd1);
        step();
        slv_rsp.r_valid = 1'b1; slv_rsp.r.id = 4'd7;
        ref_req.r_ready = 1'b1; test_req.r_ready = 1'b1;
        q_rref.push_back(4'd7); q_rtest.push_back(4'd7);
        #1 check("ar_stall_same_cycle", {30'd0, ref_rsp.ar_ready, test_rsp.ar_ready}, 32'd0);
        step();
        slv_rsp.r_valid = 1'b0;
        q_ar.push_back(32'h4000);
        #1 check("ar_unstall", {30'd0, ref_rsp.ar_ready, test_rsp.ar_ready}, 32'd3);
        step(); drop_requests();
        slv_rsp.r_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q_rref.push_back(4'd7); q_rtest.push_back(4'd7);
            step();
        end
        slv_rsp.r_valid = 1'b0; ref_req.r_ready = 1'b0; test_req.r_ready = 1'b0;
        check("ar_cnt_zero", 32'(dut.ar_cnt_q), 32'd0);

        // Reset mid-transaction, then an orphan B
        ref_req.aw.addr = 32'h5000; test_req.aw = ref_req.aw;
        ref_req.aw_valid = 1'b1; test_req.aw_valid = 1'b1;
        q_aw.push_back(32'h5000); step(); drop_requests();
        ref_req.ar.addr = 32'h6000; test_req.ar = ref_req.ar;
        ref_req.ar_valid = 1'b1; test_req.ar_valid = 1'b1;
        q_ar.push_back(32'h6000); step(); drop_requests();
        slv_rsp.r_valid = 1'b1; slv_rsp.r.id = 4'd8; slv_rsp.r.last = 1'b1;
        test_req.r_ready = 1'b1;
        q_rtest.push_back(4'd8);
        step();
        slv_rsp.r_valid = 1'b0; test_req.r_ready = 1'b0;
        check("r_done_test_set", {31'd0, dut.r_done_test_q}, 32'd1);
        rst = 1'b1;
        step();
        check("rst2_flags", {28'd0, aw_mis, w_mis, ar_mis, mis}, 32'd0);
        check("rst2_cnt", {16'd0, mis_cnt}, 32'd0);
        check("rst2_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        slv_rsp.b_valid = 1'b1; slv_rsp.b.id = 4'd9;
        ref_req.b_ready = 1'b1; test_req.b_ready = 1'b1;
        q_bref.push_back(4'd9); q_btest.push_back(4'd9);
        step();
        slv_rsp.b_valid = 1'b0; ref_req.b_ready = 1'b0; test_req.b_ready = 1'b0;
        check("orphan_b_aw_cnt", 32'(dut.aw_cnt_q), 32'd0);
        check("orphan_b_busy", {31'd0, busy}, 32'd0);
        step();

        check("queues_empty", 32'(q_aw.size() + q_w.size() + q_ar.size() + q_bref.size() +
              q_btest.size() + q_rref.size() + q_rtest.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
